bcd_display_scanner: RTL and testbench

//   Downstream stage of the game core: takes the two-digit BCD value (tens, units) and drives a

---
 rtl/bcd_display_scanner.sv | 164 ++++++++++++++++
 tb/tb_bcd_display_scanner.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed 7-segment driver for the game core's BCD score.
// Digits commit only at phase boundaries, so a digit never changes while it is lit.
module bcd_display_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 2,
   parameter int BLINK_DIV    = 64,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] bcd_tens,
   input  logic [3:0] bcd_units,
   input  logic       load,
   input  logic       blank_lz,
   input  logic       blink_en,
   output logic [1:0] an,
   output logic [6:0] seg,
   output logic       frame_tick
);

   localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [SCAN_W-1:0]  BLANK_END  = SCAN_W'(BLANK_CYCLES);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic               POL        = (ACTIVE_LOW != 0);

   typedef enum logic {
      PH_UNITS = 1'b0,
      PH_TENS  = 1'b1
   } phase_t;

   phase_t              phase_reg, phase_next;
   logic [SCAN_W-1:0]   scan_cnt_reg, scan_cnt_next;
   logic                scan_wrap;
   logic                frame_end;

   logic [3:0]          pend_tens_reg, pend_units_reg;
   logic [3:0]          com_tens_reg, com_units_reg;

   logic [BLINK_W-1:0]  blink_cnt_reg;
   logic                blink_on_reg;

   logic [3:0]          digit_val;
   logic                lz_blank;
   logic                show;
   logic [1:0]          an_on;
   logic [6:0]          seg_on;

   // ---------------- scan FSM ----------------
   assign scan_wrap = (scan_cnt_reg == SCAN_LAST);

   always_comb begin
      scan_cnt_next = scan_cnt_reg + 1'b1;
      phase_next    = phase_reg;
      frame_end     = 1'b0;
      if (scan_wrap) begin
         scan_cnt_next = '0;
         case (phase_reg)
            PH_UNITS: phase_next = PH_TENS;
            PH_TENS: begin
               phase_next = PH_UNITS;
               frame_end  = 1'b1;
            end
            default: phase_next = PH_UNITS;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_reg    <= PH_UNITS;
         scan_cnt_reg <= '0;
      end else begin
         phase_reg    <= phase_next;
         scan_cnt_reg <= scan_cnt_next;
      end
   end

   // ---------------- pending / committed digits ----------------
   // Commit samples pending before this edge's load, so a load on the
   // boundary edge waits for the next boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_tens_reg  <= '0;
         pend_units_reg <= '0;
         com_tens_reg   <= '0;
         com_units_reg  <= '0;
      end else begin
         if (load) begin
            pend_tens_reg  <= bcd_tens;
            pend_units_reg <= bcd_units;
         end
         if (scan_wrap) begin
            com_tens_reg  <= pend_tens_reg;
            com_units_reg <= pend_units_reg;
         end
      end
   end

   // ---------------- blink ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_reg <= '0;
         blink_on_reg  <= 1'b1;
      end else if (!blink_en) begin
         blink_cnt_reg <= '0;
         blink_on_reg  <= 1'b1;
      end else if (frame_end) begin
         if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= ~blink_on_reg;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
         end
      end
   end

   // ---------------- decode and enable ----------------
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   assign digit_val = (phase_reg == PH_TENS) ? com_tens_reg : com_units_reg;
   assign lz_blank  = (phase_reg == PH_TENS) && blank_lz && (com_tens_reg == 4'd0);
   assign show      = (scan_cnt_reg >= BLANK_END) && !lz_blank && !(blink_en && !blink_on_reg);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_anode
         localparam phase_t GI_PHASE = (gi == 1) ? PH_TENS : PH_UNITS;
         assign an_on[gi] = show && (phase_reg == GI_PHASE);
      end
   endgenerate

   assign seg_on = (|an_on) ? seg_decode(digit_val) : 7'h00;

   // Polarity is applied only here; everything upstream is active-high.
   always_ff @(posedge clk) begin
      if (rst) begin
         an         <= {2{POL}};
         seg        <= {7{POL}};
         frame_tick <= 1'b0;
      end else begin
         an         <= an_on ^ {2{POL}};
         seg        <= seg_on ^ {7{POL}};
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: a cycle-count based reference model queues the expected
// display word for every clock; a negedge monitor pops and compares.
module tb_bcd_display_scanner;

   localparam int SD = 4;
   localparam int BC = 1;
   localparam int BD = 2;
   localparam int AL = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] bcd_tens = '0;
   logic [3:0] bcd_units = '0;
   logic       load = 1'b0;
   logic       blank_lz = 1'b0;
   logic       blink_en = 1'b0;
   logic [1:0] an;
   logic [6:0] seg;
   logic       frame_tick;

   bcd_display_scanner #(
      .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_DIV(BD), .ACTIVE_LOW(AL)
   ) dut (
      .clk(clk), .rst(rst), .bcd_tens(bcd_tens), .bcd_units(bcd_units),
      .load(load), .blank_lz(blank_lz), .blink_en(blink_en),
      .an(an), .seg(seg), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] an;
      logic [6:0] seg;
      logic       ft;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   logic [6:0] glyph [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // ---------------- reference model ----------------
   // Position in the scan is derived purely from cycles since reset.
   int   m_t, m_bf;
   int   m_pt, m_pu, m_ct, m_cu;
   int   m_cnt, m_ph, m_dig;
   logic m_show, m_ft, m_blink_on;
   exp_t m_e;

   always @(posedge clk) begin
      if (rst) begin
         m_e.an = 2'b11; m_e.seg = 7'h7F; m_e.ft = 1'b0;
         m_t = 0; m_bf = 0; m_pt = 0; m_pu = 0; m_ct = 0; m_cu = 0;
      end else begin
         m_cnt      = m_t % SD;
         m_ph       = (m_t / SD) % 2;
         m_blink_on = ((m_bf / BD) % 2) == 0;
         m_ft       = (m_cnt == SD - 1) && (m_ph == 1);
         m_dig      = (m_ph == 1) ? m_ct : m_cu;
         m_show     = (m_cnt >= BC) && !(m_ph == 1 && blank_lz && m_ct == 0)
                      && !(blink_en && !m_blink_on);
         if (m_show) begin
            m_e.an  = (m_ph == 1) ? 2'b01 : 2'b10;
            m_e.seg = ~((m_dig > 9) ? 7'h40 : glyph[m_dig]);
         end else begin
            m_e.an  = 2'b11;
            m_e.seg = 7'h7F;
         end
         m_e.ft = m_ft;
         if (m_cnt == SD - 1) begin
            m_ct = m_pt; m_cu = m_pu;
         end
         if (load) begin
            m_pt = int'(bcd_tens); m_pu = int'(bcd_units);
         end
         m_bf = blink_en ? (m_bf + (m_ft ? 1 : 0)) : 0;
         m_t++;
      end
      q.push_back(m_e);
   end

   // ---------------- monitor ----------------
   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         chk("an", int'(an), int'(mon_e.an));
         chk("seg", int'(seg), int'(mon_e.seg));
         chk("frame_tick", int'(frame_tick), int'(mon_e.ft));
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_load(input logic [3:0] tn, input logic [3:0] un);
      bcd_tens = tn; bcd_units = un; load = 1'b1;
      $display("load at %0t: tens=%0d units=%0d", $time, tn, un);
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      do_load(4'd4, 4'd2);             idle(24);
      blank_lz = 1'b1;
      do_load(4'd0, 4'd7);             idle(24);
      blank_lz = 1'b0;                 idle(16);
      do_load(4'd4, 4'd2);             idle(17);
      do_load(4'd9, 4'd9);             idle(16);
      do_load(4'd12, 4'd15);           idle(10);
      blink_en = 1'b1;                 idle(60);
      blink_en = 1'b0;                 idle(12);
      blink_en = 1'b1;                 idle(45);
      rst = 1'b1;                      idle(2);
      rst = 1'b0; blink_en = 1'b0;     idle(12);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            bcd_tens  = 4'($urandom_range(0, 15));
            bcd_units = 4'($urandom_range(0, 15));
            load = 1'b1;
            $display("load at %0t: tens=%0d units=%0d", $time, bcd_tens, bcd_units);
         end else begin
            load = 1'b0;
         end
         if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 49) == 0) blink_en = ~blink_en;
         rst = ($urandom_range(0, 299) == 0);
         @(posedge clk); #1;
      end
      load = 1'b0; rst = 1'b0;
      idle(4);
      @(negedge clk); #1;
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
